// File: rtl/lane_hit_judge_pkg.sv
// Shared score codes and result record for the multi-lane hit judge.
// Included by lane_judge_unit and lane_hit_judge.
package lane_hit_pkg;

    localparam logic [1:0] SCORE_PERFECT = 2'b11;
    localparam logic [1:0] SCORE_LATE    = 2'b10;
    localparam logic [1:0] SCORE_EARLY   = 2'b01;
    localparam logic [1:0] SCORE_NONE    = 2'b00;

    // Lane field sized for the largest supported build (8 lanes)
    localparam int MAX_LANE_W = 3;

    typedef struct packed {
        logic [MAX_LANE_W-1:0] lane;
        logic [1:0]            score;
        logic                  miss;
    } result_t;

endpackage

// File: rtl/lane_hit_judge_if.sv
// Result port between the hit judge (master) and the scoring block (slave).
interface lane_hit_judge_if #(
    parameter int LANES = 4
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic              res_valid;
    logic              res_ready;
    logic [LANE_W-1:0] res_lane;
    logic [1:0]        res_score;
    logic              res_miss;

    modport master (output res_valid, res_lane, res_score, res_miss, input res_ready);
    modport slave  (input res_valid, res_lane, res_score, res_miss, output res_ready);
endinterface

// File: rtl/lane_hit_judge_unit.sv
// Per-lane judge: optional debounce (LANE_HIT_JUDGE_DEBOUNCE_EN), press edge, grading,
// miss detection, delete pulse and a single pending result slot.
module lane_judge_unit
    import lane_hit_pkg::*;
#(
    parameter int OFF_W     = 3,
    parameter int EARLY_OFF = 1,
    parameter int PERF_LO   = 2,
    parameter int PERF_HI   = 4,
    parameter int LATE_OFF  = 5,
    parameter int DEB_CYC   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             note_present,
    input  logic [OFF_W-1:0] offset,
    input  logic             drain,
    output logic             delete_note,
    output logic             overflow,
    output logic             pending,
    output logic [1:0]       score,
    output logic             miss
);

    localparam logic [OFF_W-1:0] EARLY_V = OFF_W'(EARLY_OFF);
    localparam logic [OFF_W-1:0] PLO_V   = OFF_W'(PERF_LO);
    localparam logic [OFF_W-1:0] PHI_V   = OFF_W'(PERF_HI);
    localparam logic [OFF_W-1:0] LATE_V  = OFF_W'(LATE_OFF);
    localparam logic [OFF_W-1:0] MISS_V  = OFF_W'(LATE_OFF + 1);

    if (DEB_CYC < 1) begin : g_bad_deb
        $error("lane_judge_unit: DEB_CYC must be at least 1");
    end

    logic btn_lvl;

`ifdef LANE_HIT_JUDGE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Filtered level flips only after DEB_CYC consecutive differing raw samples
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (btn != filt_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) filt_d = btn;
            else                              cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_lvl = filt_q;
`else
    assign btn_lvl = btn;
`endif

    logic       btn_prev_q, btn_prev_d;
    logic       miss_prev_q, miss_prev_d;
    logic       pending_q, pending_d;
    logic [1:0] score_q, score_d;
    logic       miss_q, miss_d;
    logic       delete_q, delete_d;
    logic       overflow_q, overflow_d;

    logic       hit, miss_cond, miss_evt, evt;
    logic [1:0] grade;

    // A hit in the same cycle as the miss point suppresses the miss
    always_comb begin
        hit       = btn_lvl & ~btn_prev_q & note_present;
        miss_cond = note_present & (offset == MISS_V);
        miss_evt  = miss_cond & ~miss_prev_q & ~hit;
        evt       = hit | miss_evt;

        if (offset >= PLO_V && offset <= PHI_V) grade = SCORE_PERFECT;
        else if (offset == LATE_V)              grade = SCORE_LATE;
        else if (offset == EARLY_V)             grade = SCORE_EARLY;
        else                                    grade = SCORE_NONE;

        btn_prev_d  = btn_lvl;
        miss_prev_d = miss_cond;
        delete_d    = evt;
        overflow_d  = 1'b0;
        pending_d   = pending_q & ~drain;
        score_d     = score_q;
        miss_d      = miss_q;

        if (evt) begin
            if (pending_q && !drain) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                score_d   = hit ? grade : SCORE_NONE;
                miss_d    = ~hit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q  <= 1'b0;
            miss_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            score_q     <= SCORE_NONE;
            miss_q      <= 1'b0;
            delete_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            btn_prev_q  <= btn_prev_d;
            miss_prev_q <= miss_prev_d;
            pending_q   <= pending_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            delete_q    <= delete_d;
            overflow_q  <= overflow_d;
        end
    end

    assign delete_note = delete_q;
    assign overflow    = overflow_q;
    assign pending     = pending_q;
    assign score       = score_q;
    assign miss        = miss_q;

endmodule

// File: rtl/lane_hit_judge.sv
// Multi-lane hit judge top: per-lane judge units plus a round-robin result arbiter.
// Optional input debounce is enabled with LANE_HIT_JUDGE_DEBOUNCE_EN.
module lane_hit_judge
    import lane_hit_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int OFF_W     = 3,
    parameter int EARLY_OFF = 1,
    parameter int PERF_LO   = 2,
    parameter int PERF_HI   = 4,
    parameter int LATE_OFF  = 5,
    parameter int DEB_CYC   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       btn,
    input  logic [LANES-1:0]       note_present,
    input  logic [LANES*OFF_W-1:0] offset,
    output logic [LANES-1:0]       delete_note,
    output logic                   overflow,
    lane_hit_judge_if.master       res
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("lane_hit_judge: LANES must be 1..8");
    end
    if (LATE_OFF + 1 >= (1 << OFF_W)) begin : g_bad_off
        $error("lane_hit_judge: LATE_OFF+1 does not fit in OFF_W bits");
    end

    logic [LANES-1:0] pending, lane_ovf, drain, avail;
    logic [1:0]       slot_score [LANES];
    logic             slot_miss  [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_judge_unit #(
            .OFF_W(OFF_W), .EARLY_OFF(EARLY_OFF), .PERF_LO(PERF_LO),
            .PERF_HI(PERF_HI), .LATE_OFF(LATE_OFF), .DEB_CYC(DEB_CYC)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .btn         (btn[g]),
            .note_present(note_present[g]),
            .offset      (offset[g*OFF_W +: OFF_W]),
            .drain       (drain[g]),
            .delete_note (delete_note[g]),
            .overflow    (lane_ovf[g]),
            .pending     (pending[g]),
            .score       (slot_score[g]),
            .miss        (slot_miss[g])
        );
    end

    logic              valid_q, valid_d;
    result_t           out_q, out_d;
    logic [LANE_W-1:0] rr_q, rr_d;
    logic              handshake, found;
    int                idx;

    // The presented lane is excluded from the search; it is being drained this cycle
    always_comb begin
        handshake = valid_q & res.res_ready;
        drain     = handshake ? (LANES'(1) << out_q.lane) : '0;
        avail     = pending & ~drain;
        rr_d      = rr_q;
        if (handshake) begin
            rr_d = (int'(out_q.lane) == LANES - 1) ? '0 : LANE_W'(int'(out_q.lane) + 1);
        end
        valid_d = valid_q;
        out_d   = out_q;
        found   = 1'b0;
        idx     = 0;
        if (!valid_q || handshake) begin
            valid_d = 1'b0;
            out_d   = '0;
            for (int k = 0; k < LANES; k++) begin
                idx = int'(rr_d) + k;
                if (idx >= LANES) idx = idx - LANES;
                if (!found && avail[idx]) begin
                    found       = 1'b1;
                    valid_d     = 1'b1;
                    out_d.lane  = MAX_LANE_W'(idx);
                    out_d.score = slot_score[idx];
                    out_d.miss  = slot_miss[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            rr_q    <= rr_d;
        end
    end

    assign overflow      = |lane_ovf;
    assign res.res_valid = valid_q;
    assign res.res_lane  = out_q.lane[LANE_W-1:0];
    assign res.res_score = out_q.score;
    assign res.res_miss  = out_q.miss;

endmodule
